// File: rtl/grant_data_mux_pkg.sv
// Shared arbiter definitions: requester count, index width, mux FSM states and one-hot helpers.
package grant_data_mux_pkg;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned SRC_W   = 2;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STALL_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Index of the (lowest) set bit of a one-hot vector; 0 when none is set.
  function automatic logic [SRC_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (oh[i]) idx = SRC_W'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit of the vector is set.
  function automatic logic is_onehot(input logic [N_REQ-1:0] oh);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) ones++;
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/grant_data_mux_onehot_enc.sv
// One-hot to binary index encoder with an exactly-one-hot valid flag.
module onehot_enc #(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic [N-1:0]  onehot,
  output logic [SW-1:0] idx,
  output logic          vld
);

  int unsigned ones;

  // OR together the indices of set bits and count them; idx is only meaningful when vld.
  always_comb begin
    idx  = '0;
    ones = 0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        idx  = idx | SW'(i);
        ones = ones + 1;
      end
    end
    vld = (ones == 1);
  end

endmodule

// File: rtl/grant_data_mux.sv
// Forwards the granted requester's word into a single-entry output register with valid/ready.
module grant_data_mux
  import grant_data_mux_pkg::*;
#(
  parameter int unsigned N  = N_REQ,
  parameter int unsigned DW = DATA_W,
  parameter int unsigned SW = SRC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      Grant,
  input  logic [N*DW-1:0]   req_data,
  output logic [N-1:0]      ack,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [SW-1:0]     out_src,
  input  logic              out_ready,
  output logic              grant_err,
  output logic [STALL_W-1:0] stall_cnt
);

  state_t          state;
  state_t          state_n;
  logic [SW-1:0]   grant_idx;
  logic            grant_ok;
  logic            can_load;
  logic            capture;
  logic [DW-1:0]   sel_data;

  onehot_enc #(.N(N), .SW(SW)) u_enc (
    .onehot (Grant),
    .idx    (grant_idx),
    .vld    (grant_ok)
  );

  // Select the granted lane's word.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) sel_data = req_data[i*DW +: DW];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= EMPTY;
    else      state <= state_n;
  end

  // Next state, capture decision and ack; ack forced low while in reset.
  always_comb begin
    state_n  = state;
    can_load = 1'b0;
    capture  = 1'b0;
    ack      = '0;
    case (state)
      EMPTY: can_load = 1'b1;
      FULL:  can_load = out_ready;
      default: can_load = 1'b0;
    endcase
    capture = rst && grant_ok && can_load;
    if (capture) ack = Grant;
    case (state)
      EMPTY: if (capture) state_n = FULL;
      FULL:  if (out_ready && !capture) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  assign out_valid = (state == FULL);

  // Output word/source, sticky grant error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data  <= '0;
      out_src   <= '0;
      grant_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (capture) begin
        out_data <= sel_data;
        out_src  <= grant_idx;
      end
      if ((Grant != '0) && !grant_ok) grant_err <= 1'b1;
      if (out_valid && !out_ready && (stall_cnt != {STALL_W{1'b1}}))
        stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_grant_data_mux.sv
// Self-checking bench: directed vector table, stall saturation sequence, randomized run vs model.
module tb_grant_data_mux;

  logic        clk;
  logic        rst;
  logic [3:0]  grant;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic        grant_err;
  logic [7:0]  stall_cnt;

  int unsigned n_tests;
  int unsigned n_fail;

  grant_data_mux dut (
    .clk       (clk),
    .rst       (rst),
    .Grant     (grant),
    .req_data  (req_data),
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .grant_err (grant_err),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a one-word buffer described by the handshake rules.
  bit          m_held;
  int unsigned m_data;
  int unsigned m_src;
  bit          m_err;
  int unsigned m_stall;
  logic [3:0]  m_ack;
  logic [3:0]  act_ack;

  typedef struct {
    logic        r;
    logic [3:0]  g;
    logic [31:0] d;
    logic        rdy;
    logic [3:0]  e_ack;
    logic        e_valid;
    logic [7:0]  e_data;
    logic [1:0]  e_src;
    logic        e_err;
    logic [7:0]  e_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, record comb ack before the edge, advance model on the edge.
  task automatic apply(input logic r, input logic [3:0] g, input logic [31:0] d, input logic rdy);
    int unsigned ones;
    int unsigned idx;
    bit cap;
    @(negedge clk);
    rst = r; grant = g; req_data = d; out_ready = rdy;
    #1;
    act_ack = ack;
    ones = $countones(g);
    idx = 0;
    for (int i = 0; i < 4; i++) if (g[i]) idx = i;
    cap = r && (ones == 1) && (!m_held || rdy);
    m_ack = cap ? g : 4'b0000;
    @(posedge clk);
    if (!r) begin
      m_held = 0; m_data = 0; m_src = 0; m_err = 0; m_stall = 0;
    end else begin
      if (m_held && !rdy && m_stall < 255) m_stall++;
      if (ones > 1) m_err = 1;
      if (cap) begin
        m_held = 1;
        m_data = (d >> (idx * 8)) & 32'hFF;
        m_src  = idx;
      end else if (rdy) begin
        m_held = 0;
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".ack"},       act_ack,   m_ack);
    check({tag, ".out_valid"}, out_valid, m_held);
    if (m_held) begin
      check({tag, ".out_data"}, out_data, m_data);
      check({tag, ".out_src"},  out_src,  m_src);
    end
    check({tag, ".grant_err"}, grant_err, m_err);
    check({tag, ".stall_cnt"}, stall_cnt, m_stall);
  endtask

  function automatic vec_t mk(logic r, logic [3:0] g, logic [31:0] d, logic rdy, logic [3:0] ea,
                              logic ev, logic [7:0] ed, logic [1:0] es, logic ee, logic [7:0] est);
    vec_t v;
    v.r = r; v.g = g; v.d = d; v.rdy = rdy; v.e_ack = ea; v.e_valid = ev;
    v.e_data = ed; v.e_src = es; v.e_err = ee; v.e_stall = est;
    return v;
  endfunction

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b0; grant = '0; req_data = '0; out_ready = 1'b0;
    m_held = 0; m_data = 0; m_src = 0; m_err = 0; m_stall = 0;

    // r, grant, data, ready | ack, valid, data, src, err, stall (outputs after the edge)
    vecs.push_back(mk(0, 4'b0000, 32'h0,         0, 4'b0000, 0, 8'h00, 2'd0, 0, 8'd0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 4'b0000, 32'h0,       0, 4'b0000, 0, 8'h00, 2'd0, 0, 8'd0));
    vecs.push_back(mk(1, 4'b0100, 32'h00A5_0000, 1, 4'b0100, 1, 8'hA5, 2'd2, 0, 8'd0));
    vecs.push_back(mk(1, 4'b0010, 32'h0000_1000, 1, 4'b0010, 1, 8'h10, 2'd1, 0, 8'd0));
    vecs.push_back(mk(1, 4'b0010, 32'h0000_1100, 1, 4'b0010, 1, 8'h11, 2'd1, 0, 8'd0));
    vecs.push_back(mk(1, 4'b0010, 32'h0000_1200, 1, 4'b0010, 1, 8'h12, 2'd1, 0, 8'd0));
    vecs.push_back(mk(1, 4'b0010, 32'h0000_1300, 1, 4'b0010, 1, 8'h13, 2'd1, 0, 8'd0));
    vecs.push_back(mk(1, 4'b1000, 32'h7700_0000, 0, 4'b0000, 1, 8'h13, 2'd1, 0, 8'd1));
    vecs.push_back(mk(1, 4'b1000, 32'h7700_0000, 0, 4'b0000, 1, 8'h13, 2'd1, 0, 8'd2));
    vecs.push_back(mk(1, 4'b1000, 32'h7700_0000, 0, 4'b0000, 1, 8'h13, 2'd1, 0, 8'd3));
    vecs.push_back(mk(1, 4'b1000, 32'h7700_0000, 1, 4'b1000, 1, 8'h77, 2'd3, 0, 8'd3));
    vecs.push_back(mk(1, 4'b0011, 32'h0000_0000, 1, 4'b0000, 0, 8'h77, 2'd3, 1, 8'd3));
    vecs.push_back(mk(1, 4'b0001, 32'h0000_00C3, 1, 4'b0001, 1, 8'hC3, 2'd0, 1, 8'd3));
    vecs.push_back(mk(1, 4'b0001, 32'h0000_00C4, 0, 4'b0000, 1, 8'hC3, 2'd0, 1, 8'd4));
    vecs.push_back(mk(0, 4'b0001, 32'h0000_00C4, 0, 4'b0000, 0, 8'h00, 2'd0, 0, 8'd0));
    vecs.push_back(mk(1, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h00, 2'd0, 0, 8'd0));

    foreach (vecs[k]) begin
      apply(vecs[k].r, vecs[k].g, vecs[k].d, vecs[k].rdy);
      check($sformatf("vec%0d.ack", k),       act_ack,   vecs[k].e_ack);
      check($sformatf("vec%0d.out_valid", k), out_valid, vecs[k].e_valid);
      check($sformatf("vec%0d.out_data", k),  out_data,  vecs[k].e_data);
      check($sformatf("vec%0d.out_src", k),   out_src,   vecs[k].e_src);
      check($sformatf("vec%0d.grant_err", k), grant_err, vecs[k].e_err);
      check($sformatf("vec%0d.stall_cnt", k), stall_cnt, vecs[k].e_stall);
    end

    // Stall counter saturation while a word is held, then drain.
    apply(1, 4'b0001, 32'h0000_005A, 1);
    check("sat.load_ack", act_ack, 4'b0001);
    for (int i = 0; i < 260; i++) apply(1, 4'b0000, 32'h0, 0);
    check("sat.stall_cnt", stall_cnt, 8'd255);
    check("sat.out_data", out_data, 8'h5A);
    check("sat.out_valid", out_valid, 1'b1);
    apply(1, 4'b0000, 32'h0, 1);
    check("sat.drain_valid", out_valid, 1'b0);
    check("sat.drain_stall", stall_cnt, 8'd255);
    apply(0, 4'b0000, 32'h0, 0);
    check("sat.reset_stall", stall_cnt, 8'd0);

    // Randomized traffic checked against the model.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] g;
      logic       r;
      int unsigned pick;
      pick = $urandom_range(0, 9);
      if (pick < 2)      g = 4'b0000;
      else if (pick < 9) g = 4'b0001 << $urandom_range(0, 3);
      else               g = 4'($urandom);
      r = ($urandom_range(0, 39) != 0);
      apply(r, g, $urandom, 1'($urandom_range(0, 1)));
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/grant_data_mux.md
Name: grant_data_mux

Overview:
- Sits directly downstream of the 4-requester round-robin arbiter.
- Consumes the arbiter's one-hot Grant and forwards the granted requester's data word into a single-entry registered output stage, with a valid/ready handshake to the shared consumer.
- Returns a per-requester ack pulse so the requester can drop or advance its Req.
- Provides a sticky error flag for illegal grants and a saturating stall counter for debug.

Parameters:
- N, 4, number of requesters; must match the arbiter width.
- DW, 8, data width per requester.
- SW, 2, source-index width (clog2 of N).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-low (rst==0 at a rising edge of clk resets).
- Grant  input  N  one-hot grant from the arbiter; all-zero means idle.
- req_data  input  N*DW  packed data; requester i occupies bits [i*DW +: DW].
- ack  output  N  combinational one-hot pulse; bit i is high in the cycle requester i's word is captured.
- out_valid  output  1  output register holds a word.
- out_data  output  DW  captured word.
- out_src  output  SW  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- grant_err  output  1  sticky; set when Grant has more than one bit high.
- stall_cnt  output  8  saturating count of cycles with out_valid && !out_ready.

Behaviour:
- Reset values (rst==0 at clk edge): out_valid=0, out_data=0, out_src=0, grant_err=0, stall_cnt=0, FSM in EMPTY.
  - ack is combinational and is 0 while rst==0.
  - Reset mid-transfer discards the held word with no ack and no handshake.
- Grant decode:
  - grant_ok = Grant is exactly one-hot.
  - grant_idx = position of the set bit.
  - Grant with more than one bit high sets grant_err on the next edge; that cycle captures nothing and acks nothing.
  - Grant==0 is legal idle.
- can_load = (state==EMPTY) || (state==FULL && out_ready).
- capture = grant_ok && can_load.
- ack = capture ? Grant : 0, so at most one bit is high per cycle.
- FSM, two states:
  - EMPTY: on capture, go to FULL with out_valid=1, out_data=req_data[grant_idx], out_src=grant_idx. Otherwise stay in EMPTY.
  - FULL, out_ready=0: hold out_data and out_src unchanged, ack=0, Grant ignored.
  - FULL, out_ready=1 with capture: stay in FULL and load the new word on the same edge. This gives back-to-back throughput of 1 word/cycle with no bubble.
  - FULL, out_ready=1 without capture: go to EMPTY with out_valid=0. out_data and out_src hold their last values.
- Latency: data present with Grant in cycle t appears on out_data/out_valid in cycle t+1.
- Requester contract: the arbiter keeps granting a requester while its Req is high. A requester that sees ack in cycle t must present its next word or drop Req by cycle t+1; otherwise the same word is captured again.
- stall_cnt increments each cycle out_valid && !out_ready, saturates at 255, and clears only on reset.
- grant_err clears only on reset.
- No combinational path from out_ready to out_valid. A combinational path from out_ready to ack is allowed.

Decomposition:
- Shared arbiter package holds:
  - constants N_REQ=4 and SRC_W=2, shared with the arbiter;
  - state typedef {EMPTY, FULL};
  - the onehot_to_idx function and is_onehot function, also usable by the arbiter.
- One sub-module is natural: onehot_enc (N-bit one-hot to SW-bit index plus valid flag), instantiated once. Everything else stays in grant_data_mux.

Test Plan:
- Reset, then Grant=4'b0000 for 5 cycles -> out_valid=0, ack=0, stall_cnt=0, grant_err=0.
- Grant=4'b0100, req_data lane2=8'hA5, out_ready=1 -> ack=4'b0100 in cycle t; out_valid=1, out_data=8'hA5, out_src=2 in t+1.
- Grant=4'b0010 every cycle with lane1 data incrementing 8'h10..8'h13, out_ready=1 -> four consecutive outputs 10,11,12,13 with no bubble; ack=4'b0010 in each capture cycle.
- Word held with out_ready=0 for 3 cycles while Grant=4'b1000 -> out_data stable, ack=0, stall_cnt=3. Then out_ready=1 -> lane3 word captured the same cycle, ack=4'b1000.
- Grant=4'b0011 -> no capture, ack=0, grant_err=1 from the next cycle and stays 1 after Grant returns to 4'b0001 (which captures normally).
- FULL state, rst=0 for one edge -> out_valid=0 and stall_cnt=0 next cycle; the held word is never handed off.
